k2_bank_exec: RTL and testbench
===============================

# k2_bank_exec

Parametrised execution harness around `K2_processor`:
- Holds `PROG_BANKS` writable 16-instruction program slots, loaded through a valid/ready port.
- Runs a selected bank under a start/busy/done control FSM, with halt detection and a cycle timeout.
- Streams every change of the core's `Ro` output into a small FIFO with valid/ready drain.

It replaces fixed single-ROM program wrappers as the top-level test and demo vehicle for the processor.

## Interface
Parameters:
- `BITS`, 8: core datapath width; width of `Ro` and `out_data`.
- `PROG_BANKS`, 2: number of program slots, each 16 × 8-bit.
- `OUT_DEPTH`, 4: capture FIFO entries; power of 2, ≥ 2.
- `MAX_CYCLES`, 255: run cycles before forced stop.
- `BW`: derived, max(1, $clog2(`PROG_BANKS`)).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  instruction write request.
- `load_ready`  out  1  high only in IDLE.
- `load_bank`  in  BW  target slot.
- `load_addr`  in  4  instruction address within slot.
- `load_data`  in  8  instruction word.
- `start`  in  1  run request, sampled in IDLE only.
- `run_bank`  in  BW  slot to execute, latched on accepted start.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `timeout`  out  1  sticky; set when the run ended by `MAX_CYCLES`; cleared on the next accepted start.
- `overflow`  out  1  sticky; a capture was dropped because the FIFO was full; cleared on the next accepted start.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer pop.
- `out_data`  out  BITS  FIFO head.
- `ro_live`  out  BITS  direct core `Ro`.

## Operation
- **Program memory:** `PROG_BANKS`×16 × 8 registers, not reset.
  - Write on `load_valid & load_ready` at {`load_bank`, `load_addr`}.
  - Out-of-range bank (≥ `PROG_BANKS`) is ignored.
  - Core fetch is a combinational read of {`bank_q`, `ProgramAddress`} into `instruction_data`.
- **Core reset:** core `rst_n` = registered (state == RUN), so the core is held in reset outside RUN and in the first RUN cycle.
- **FSM states:**
  - IDLE: `load_ready` = 1. Accepted start latches `bank_q`, clears the cycle counter, `timeout`, `overflow`, `prev_ro` (to 0) and FIFO pointers, then goes to RUN.
  - RUN: cycle counter increments every cycle. `start` and `load_valid` are ignored.
  - Halt: `ProgramAddress` equal to its previous-cycle value (jump-to-self), evaluated only after the core's reset has been released ≥ 2 cycles. Halt → DONE.
  - Timeout: counter == `MAX_CYCLES` → DONE with `timeout` ← 1. Halt and timeout in the same cycle: halt wins, `timeout` stays 0.
  - DONE: `done` = 1 for one cycle, then → IDLE.
- **Load and start in the same IDLE cycle:** the write completes, start is accepted, and the core sees the new word.
- **Capture (RUN only):** when the core's reset is released and `Ro` ≠ `prev_ro`, push `Ro` and update `prev_ro`.
  - If the FIFO is full and no pop occurs that cycle, drop the value and set `overflow`.
  - A simultaneous push and pop on a full FIFO is legal.
- **FIFO:** circular with `$clog2(OUT_DEPTH)+1`-bit pointers, so full and empty are distinguishable. Pointers wrap modulo 2·`OUT_DEPTH`.
  - Drains in any state, except that the FIFO is cleared on an accepted start.
  - A pop when empty is ignored.
- **Reset mid-run:** immediate return to IDLE; FIFO emptied; flags cleared; memory contents retained.

## Timing
- **Reset values:** `busy`, `done`, `timeout`, `overflow`, `out_valid` = 0. `load_ready` = 1 (IDLE). `out_data` = 0. `ro_live` follows the held core.
- **Start:** accepted at edge t → `busy` = 1 from t+1. Core reset released at t+2; first fetch of address 0 at t+2.
- **Capture:** a `Ro` change visible in cycle c → `out_valid`/`out_data` at c+1.
- **Halt:** detected at cycle h → `busy` = 0 and `done` = 1 at h+1 → `load_ready` = 1 at h+2.
- **Timeout:** occurs exactly `MAX_CYCLES` RUN cycles after entering RUN.
- **Load:** single-cycle; a back-to-back write every cycle is sustainable.

## Test plan
- **Reset state:** assert `rst` asynchronously between edges → all outputs at reset values immediately. Release → `load_ready` = 1 on the next cycle.
- **Fibonacci run:** load the team's Fibonacci program into bank 1 with `out_ready` = 1, then pulse start with `run_bank` = 1. Required: captured stream begins 1,2,3,5,8,13; `timeout` = 1 and `done` pulse exactly 255 cycles after RUN entry.
- **Halt:** bank 0 = program loading 7 into the output then jump-to-self at address 2. Required: single capture 7; `done` within 5 cycles of start; `timeout` = 0.
- **Backpressure:** Fibonacci run with `out_ready` = 0 and `OUT_DEPTH` = 4. Required: exactly 4 entries (1,2,3,5) and `overflow` = 1. Then `out_ready` = 1 → pops 1,2,3,5 in order, then `out_valid` = 0.
- **Ignored requests in RUN:** `start` and `load_valid` asserted during RUN → `load_ready` = 0 and memory unchanged (verified by re-running).
- **Reset mid-run:** `rst` asserted at RUN cycle 10, then restart on the same bank → identical capture stream (memory retained).

Source files
------------

// File: rtl/k2_bank_exec.sv
// k2_bank_exec: banked program store and start/busy/done run control around K2_processor; Ro changes go to a FIFO.
// Capture visible one cycle after the Ro change; FIFO drains on out_ready; a full FIFO with no pop drops and flags overflow.
module K2_processor #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      instruction_data,
   output logic [3:0]      ProgramAddress,
   output logic [BITS-1:0] Ro
);
   // ISA: 00 ldi d,imm4 | 01 add d (r0+r1) | 10 mov d,s | 11 jmp imm4 ; r2 is the output register
   logic [BITS-1:0] regs [4];
   logic [1:0]      op;
   logic [1:0]      dst;
   logic [1:0]      src;
   logic [3:0]      imm;

   assign op  = instruction_data[7:6];
   assign dst = instruction_data[5:4];
   assign src = instruction_data[3:2];
   assign imm = instruction_data[3:0];
   assign Ro  = regs[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ProgramAddress <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         ProgramAddress <= ProgramAddress + 4'd1;
         case (op)
            2'b00:   regs[dst] <= BITS'(imm);
            2'b01:   regs[dst] <= regs[0] + regs[1];
            2'b10:   regs[dst] <= regs[src];
            default: ProgramAddress <= imm;
         endcase
      end
   end
endmodule

module k2_bank_exec #(
   parameter int BITS       = 8,
   parameter int PROG_BANKS = 2,
   parameter int OUT_DEPTH  = 4,
   parameter int MAX_CYCLES = 255,
   localparam int BW        = (PROG_BANKS > 1) ? $clog2(PROG_BANKS) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [BW-1:0]   load_bank,
   input  logic [3:0]      load_addr,
   input  logic [7:0]      load_data,
   input  logic            start,
   input  logic [BW-1:0]   run_bank,
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic            overflow,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_data,
   output logic [BITS-1:0] ro_live
);
   localparam int PW = $clog2(OUT_DEPTH) + 1;
   localparam int AW = PW - 1;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [7:0]      prog [2**(BW+4)];
   logic [BW-1:0]   bank_q;
   logic            core_rst_n;
   logic [1:0]      rel_cnt;
   logic [3:0]      pc;
   logic [3:0]      pc_prev;
   logic [7:0]      instr;
   logic [CW-1:0]   cyc_cnt;
   logic [BITS-1:0] ro;
   logic [BITS-1:0] prev_ro;
   logic [BITS-1:0] fifo_mem [OUT_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            load_fire;
   logic            start_fire;
   logic            halt;
   logic            tmo_hit;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            cap;
   logic            push;
   logic            drop;

   assign instr = prog[{bank_q, pc}];

   K2_processor #(.BITS(BITS)) u_core (
      .clk              (clk),
      .rst_n            (core_rst_n),
      .instruction_data (instr),
      .ProgramAddress   (pc),
      .Ro               (ro)
   );

   assign ro_live    = ro;
   assign load_fire  = load_valid & load_ready;
   assign start_fire = start & (state == S_IDLE);
   // rel_cnt guards against the held-at-zero PC looking like a jump-to-self right after release
   assign halt       = (state == S_RUN) && (rel_cnt == 2'd2) && (pc == pc_prev);
   assign tmo_hit    = (state == S_RUN) && (cyc_cnt == CW'(MAX_CYCLES - 1));

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = out_ready & ~fifo_empty;
   assign cap        = (state == S_RUN) && core_rst_n && (ro != prev_ro);
   assign push       = cap && (!fifo_full || pop);
   assign drop       = cap && fifo_full && !pop;
   assign out_valid  = ~fifo_empty;
   assign out_data   = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            load_ready = 1'b1;
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (halt || tmo_hit) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         core_rst_n <= 1'b0;
         rel_cnt    <= '0;
         pc_prev    <= '0;
         bank_q     <= '0;
         cyc_cnt    <= '0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
         prev_ro    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         core_rst_n <= (state == S_RUN);
         pc_prev    <= pc;
         if (!core_rst_n)          rel_cnt <= '0;
         else if (rel_cnt != 2'd2) rel_cnt <= rel_cnt + 2'd1;
         if (start_fire) begin
            bank_q   <= run_bank;
            cyc_cnt  <= '0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            prev_ro  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (state == S_RUN)   cyc_cnt  <= cyc_cnt + CW'(1);
            if (tmo_hit && !halt) timeout  <= 1'b1;
            if (drop)             overflow <= 1'b1;
            if (cap)              prev_ro  <= ro;
            if (push)             wr_ptr   <= wr_ptr + PW'(1);
            if (pop)              rd_ptr   <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_fire && (int'(load_bank) < PROG_BANKS)) prog[{load_bank, load_addr}] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= ro;
   end
endmodule

// File: tb/tb_k2_bank_exec.sv
// Randomized scoreboard bench for k2_bank_exec against an instruction-level reference model.
module tb_k2_bank_exec;
   localparam int BITS  = 8;
   localparam int BANKS = 2;
   localparam int DEPTH = 4;
   localparam int MAXC  = 255;
   localparam int BW    = 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load_valid = 1'b0;
   logic            load_ready;
   logic [BW-1:0]   load_bank = '0;
   logic [3:0]      load_addr = '0;
   logic [7:0]      load_data = '0;
   logic            start = 1'b0;
   logic [BW-1:0]   run_bank = '0;
   logic            busy;
   logic            done;
   logic            timeout;
   logic            overflow;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [BITS-1:0] out_data;
   logic [BITS-1:0] ro_live;

   k2_bank_exec #(.BITS(BITS), .PROG_BANKS(BANKS), .OUT_DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .load_bank(load_bank),
      .load_addr(load_addr), .load_data(load_data), .start(start), .run_bank(run_bank), .busy(busy),
      .done(done), .timeout(timeout), .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .ro_live(ro_live)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         nchecks = 0;
   int         nerrs   = 0;
   logic [7:0] mem_m [BANKS][16];
   logic [7:0] pbuf [16];
   logic [7:0] exp_q [$];
   logic [7:0] obs_q [$];
   logic [7:0] ref_q [$];
   int         m_done_off;
   bit         m_tmo;
   bit         m_ovf;
   int         fib_ref [6] = '{1, 2, 3, 5, 8, 13};
   int         bp_ref  [4] = '{1, 2, 3, 5};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrs++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Executes the program as an instruction stream, indexed by RUN cycle k (k=0 is RUN entry).
   task automatic model_run(input int b, input bit drain);
      logic [7:0] r [4];
      logic [7:0] prev;
      logic [7:0] ins;
      int         pc, pc_prev, ncap;
      bit         fin;
      for (int i = 0; i < 4; i++) r[i] = '0;
      pc = 0; pc_prev = 0; prev = '0; ncap = 0; fin = 0;
      m_ovf = 0; m_tmo = 0; m_done_off = 0;
      for (int k = 0; k < MAXC && !fin; k++) begin
         if (k >= 1 && r[2] != prev) begin
            prev = r[2];
            if (drain || ncap < DEPTH) exp_q.push_back(r[2]);
            else m_ovf = 1;
            ncap++;
         end
         if (k >= 3 && pc == pc_prev) begin
            m_done_off = k + 1; fin = 1;
         end else if (k == MAXC - 1) begin
            m_done_off = k + 1; m_tmo = 1; fin = 1;
         end else if (k >= 1) begin
            ins = mem_m[b][pc]; pc_prev = pc; pc = (pc + 1) % 16;
            case (ins[7:6])
               2'd0:    r[ins[5:4]] = {4'd0, ins[3:0]};
               2'd1:    r[ins[5:4]] = r[0] + r[1];
               2'd2:    r[ins[5:4]] = r[ins[3:2]];
               default: pc = int'(ins[3:0]);
            endcase
         end
      end
   endtask

   task automatic load_buf(input int b);
      int ord [16];
      int j, t;
      for (int i = 0; i < 16; i++) ord[i] = i;
      for (int i = 15; i > 0; i--) begin
         j = $urandom_range(i, 0); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1; load_bank = BW'(b); load_addr = 4'(ord[i]); load_data = pbuf[ord[i]];
         @(posedge clk); #1;
         mem_m[b][ord[i]] = pbuf[ord[i]];
      end
      load_valid = 1'b0;
   endtask

   task automatic do_run(input int b, input bit drain, input bit disturb, input bit ld_en,
                         input int ld_a, input logic [7:0] ld_d);
      int a_cyc, waited;
      bit got;
      @(negedge clk);
      check("idle_ready", load_ready, 1);
      @(posedge clk); #1;
      if (ld_en) begin
         mem_m[b][ld_a] = ld_d;
         load_valid = 1'b1; load_bank = BW'(b); load_addr = 4'(ld_a); load_data = ld_d;
      end
      obs_q.delete();
      model_run(b, drain);
      start = 1'b1; run_bank = BW'(b);
      @(posedge clk); #1;
      start = 1'b0; load_valid = 1'b0; a_cyc = cyc;
      got = 0; waited = 0;
      while (!got && waited < 400) begin
         @(negedge clk);
         if (waited == 0) begin
            check("busy_first", busy, 1);
            check("ready_in_run", load_ready, 0);
         end
         if (done) begin
            got = 1;
            check("done_offset", cyc - a_cyc, m_done_off);
            check("timeout", timeout, m_tmo);
            check("busy_in_done", busy, 0);
         end
         @(posedge clk); #1;
         if (disturb) begin
            start      = (waited >= 1 && waited < 8);
            load_valid = start;
            load_bank  = BW'($urandom);
            load_addr  = 4'($urandom);
            load_data  = 8'($urandom);
            run_bank   = BW'($urandom);
         end
         waited++;
      end
      start = 1'b0; load_valid = 1'b0;
      if (!got) begin
         nchecks++; nerrs++;
         $display("FAIL run_bound: got no done within %0d cycles, expected done", waited);
      end
      @(negedge clk);
      check("done_pulse", done, 0);
      check("ready_after", load_ready, 1);
      check("overflow", overflow, m_ovf);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("drained", exp_q.size(), 0);
   endtask

   task automatic cmp_ref(input string nm);
      check(nm, obs_q.size(), ref_q.size());
      for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) check(nm, obs_q[i], ref_q[i]);
   endtask

   function automatic logic [7:0] rand_instr();
      return 8'($urandom);
   endfunction

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid === 1'b1 && out_ready) begin
               obs_q.push_back(out_data);
               if (exp_q.size() == 0) begin
                  nchecks++; nerrs++;
                  $display("FAIL out_extra: got %0d, expected no output", out_data);
               end else begin
                  check("out_data", out_data, exp_q.pop_front());
               end
            end
         end
      join_none

      #1 rst = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_overflow", overflow, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_load_ready", load_ready, 1);
      check("rst_ro_live", ro_live, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", load_ready, 1);
      @(posedge clk); #1;

      pbuf = '{8'h00, 8'h11, 8'h60, 8'h84, 8'h98, 8'hC2, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load_buf(1);
      pbuf = '{8'h07, 8'hA0, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load_buf(0);

      // Fibonacci to timeout, with start/load requests thrown at it during RUN
      do_run(1, 1, 1, 0, 0, 8'h00);
      wait_drain();
      check("fib_len", obs_q.size() >= 6, 1);
      for (int i = 0; i < 6 && i < obs_q.size(); i++) check("fib_head", obs_q[i], fib_ref[i]);
      ref_q = obs_q;

      do_run(1, 1, 0, 0, 0, 8'h00);
      wait_drain();
      cmp_ref("fib_rerun");

      do_run(0, 1, 0, 0, 0, 8'h00);
      wait_drain();
      check("halt_len", obs_q.size(), 1);
      if (obs_q.size() > 0) check("halt_val", obs_q[0], 7);

      do_run(0, 1, 0, 1, 0, 8'h09);
      wait_drain();
      check("ldstart_len", obs_q.size(), 1);
      if (obs_q.size() > 0) check("ldstart_val", obs_q[0], 9);

      out_ready = 1'b0;
      do_run(1, 0, 0, 0, 0, 8'h00);
      check("bp_valid", out_valid, 1);
      check("bp_head", out_data, 1);
      check("bp_pending", exp_q.size(), DEPTH);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain();
      @(negedge clk);
      check("bp_empty", out_valid, 0);
      check("bp_len", obs_q.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < obs_q.size(); i++) check("bp_order", obs_q[i], bp_ref[i]);

      @(posedge clk); #1;
      obs_q.delete();
      model_run(1, 1);
      start = 1'b1; run_bank = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", load_ready, 1);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_timeout", timeout, 0);
      check("mid_rst_ro", ro_live, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      do_run(1, 1, 0, 0, 0, 8'h00);
      wait_drain();
      cmp_ref("rst_rerun");

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) pbuf[i] = rand_instr();
         load_buf(0);
         repeat ($urandom_range(3, 0)) begin
            @(posedge clk); #1;
         end
         do_run(0, 1, 0, 0, 0, 8'h00);
         wait_drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end
endmodule
